// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: 2-flop sync, debounce FSM, one-pulse t_out for a TFF.
// Define TOGGLE_PULSE_GEN_AUTO_REPEAT_EN to emit repeat pulses while the button is held.
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             t_out,
    output logic             btn_stable,
    output logic [CNT_W-1:0] press_cnt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    state_e           state_q;
    logic             s1_q;
    logic             btn_s_q;
    logic [DW-1:0]    cnt_q;
    logic             t_q;
    logic             stable_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic             rpt_fire;

`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    logic [RW-1:0] rpt_q;
    logic          rpt_first_q;
    logic [RW-1:0] rpt_last;

    // First repeat waits the long delay, later ones use the shorter period.
    assign rpt_last = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_fire = (state_q == HELD) && btn_s_q && (rpt_q == rpt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (state_q != HELD || !btn_s_q) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (rpt_fire) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q <= rpt_q + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_q         <= 1'b0;
            stable_q    <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            s1_q    <= btn_in;
            btn_s_q <= s1_q;
            t_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_q     <= HELD;
                        t_q         <= 1'b1;
                        stable_q    <= 1'b1;
                        press_cnt_q <= press_cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end else if (rpt_fire) begin
                        t_q         <= 1'b1;
                        press_cnt_q <= press_cnt_q + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s_q) begin
                        state_q <= HELD;
                    end else if (cnt_q == DB_LAST) begin
                        state_q  <= IDLE;
                        stable_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign t_out      = t_q;
    assign btn_stable = stable_q;
    assign press_cnt  = press_cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: pulse times and counts predicted from the stimulus
// and checked against t_out through a scoreboard queue.
module tb_toggle_pulse_gen;
    localparam int DEB = 4;
    localparam int RD  = 16;
    localparam int RP  = 8;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       t_out;
    logic       btn_stable;
    logic [7:0] press_cnt;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = '0;
    logic       prev_t = 1'b0;
    exp_t       sb[$];
    exp_t       e;

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_out     (t_out),
        .btn_stable(btn_stable),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && t_out) begin
            chk("t_out_consec", int'(prev_t), 0);
            chk("pulse_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("pulse_cnt", int'(press_cnt), int'(e.cnt));
            end
        end
        prev_t = t_out;
    end

    task automatic push_pulse(input int at);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{at, exp_cnt});
    endtask

    // Clean press held for 'hold' cycles (>= DEB+4), then a clean release.
    task automatic press(input int hold);
        int n;
        int t;
        n = cyc;
        btn_in = 1'b1;
        push_pulse(n + DEB + 3);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
        t = n + DEB + 3 + RD;
        while (t <= n + hold + 2) begin
            push_pulse(t);
            t += RP;
        end
`else
        t = 0;
`endif
        repeat (DEB + 2) @(negedge clk);
        chk("stable_pre_rise", int'(btn_stable), 0);
        @(negedge clk);
        chk("stable_rise", int'(btn_stable), 1);
        repeat (hold - DEB - 3) @(negedge clk);
        btn_in = 1'b0;
        repeat (DEB + 2) @(negedge clk);
        chk("stable_pre_fall", int'(btn_stable), 1);
        @(negedge clk);
        chk("stable_fall", int'(btn_stable), 0);
        repeat (3) @(negedge clk);
        chk("press_cnt", int'(press_cnt), int'(exp_cnt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        // reset with button held
        btn_in = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_t_out", int'(t_out), 0);
            chk("rst_stable", int'(btn_stable), 0);
            chk("rst_cnt", int'(press_cnt), 0);
        end
        btn_in = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // clean press
        press(20);

        // bounce on press
        for (int p = 0; p < 4; p++) begin
            btn_in = (p % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                chk("bounce_stable", int'(btn_stable), 0);
            end
        end
        btn_in = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("bounce_low_stable", int'(btn_stable), 0);
        end
        chk("bounce_cnt", int'(press_cnt), int'(exp_cnt));

        // bounce on release
        n = cyc;
        btn_in = 1'b1;
        push_pulse(n + DEB + 3);
        repeat (12) @(negedge clk);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rel_bounce_stable", int'(btn_stable), 1);
        end
        btn_in = 1'b0;
        repeat (DEB + 2) @(negedge clk);
        chk("rel_pre_fall", int'(btn_stable), 1);
        @(negedge clk);
        chk("rel_fall", int'(btn_stable), 0);
        repeat (3) @(negedge clk);
        chk("rel_cnt", int'(press_cnt), int'(exp_cnt));

        // wrap: 256 presses in total so far
        for (int i = 0; i < 254; i++) press(8);
        chk("wrap_zero", int'(press_cnt), 0);

        // reset in the middle of PRESS_WAIT with the button held
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", int'(press_cnt), 0);
        chk("async_rst_stable", int'(btn_stable), 0);
        exp_cnt = '0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_t_out", int'(t_out), 0);
        end
        rst = 1'b0;
        r = cyc;
        push_pulse(r + DEB + 3);
        repeat (12) @(negedge clk);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_cnt", int'(press_cnt), 1);

        // long hold: repeat pulses only when the feature is built in
        press(50);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
